// File: rtl/pipe_pkg.sv
// Shared pipeline types: bubble word, control enums/structs, per-stage payloads.
// Payload widths feed pipe_stage_buf's WIDTH through $bits().
package pipe_pkg;

  localparam logic [31:0] PIPE_NOP = 32'h0000_0000;

  typedef enum logic [2:0] {
    LD_NONE,
    LD_LB,
    LD_LBU,
    LD_LH,
    LD_LHU,
    LD_LW
  } LoadType;

  typedef enum logic [1:0] {
    ST_NONE,
    ST_SB,
    ST_SH,
    ST_SW
  } StoreType;

  typedef struct packed {
    logic cp0_wr;
    logic hi_wr;
    logic lo_wr;
    logic rf_wr;
  } RegsWrType;

  typedef struct packed {
    logic has_exc;
    logic in_delay;
    logic eret;
    logic syscall;
    logic brk;
    logic ri;
    logic ov;
    logic adel_if;
  } ExceptinPipeType;

  typedef struct packed {
    logic [31:0]     pc_add1;
    logic [31:0]     instr;
    ExceptinPipeType exc;
  } IfIdPayload;

  typedef struct packed {
    logic [31:0]     pc_add1;
    logic [31:0]     instr;
    logic [31:0]     rs_data;
    logic [31:0]     rt_data;
    logic [4:0]      wr_reg;
    LoadType         ld;
    StoreType        st;
    RegsWrType       wr;
    ExceptinPipeType exc;
  } IdExePayload;

  typedef struct packed {
    logic [31:0]     pc_add1;
    logic [31:0]     alu_out;
    logic [31:0]     st_data;
    logic [4:0]      wr_reg;
    LoadType         ld;
    StoreType        st;
    RegsWrType       wr;
    ExceptinPipeType exc;
  } ExeMemPayload;

  typedef struct packed {
    logic [31:0] pc_add1;
    logic [31:0] wb_data;
    logic [4:0]  wr_reg;
    RegsWrType   wr;
  } MemWbPayload;

  function automatic logic is_bubble(input logic [31:0] w);
    return w == PIPE_NOP;
  endfunction

endpackage

// File: rtl/pipe_buf_mem.sv
// DEPTH x WIDTH register-array storage for pipe_stage_buf.
// One synchronous write port, one asynchronous read port; no reset on data.
module pipe_buf_mem #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int PW    = 1
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [PW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pipe_stage_buf.sv
// Elastic multi-entry pipeline register with valid/ready, flush and bubble-zero output.
// Optional saturating stall counter when PIPE_STALL_CNT_EN is defined.
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
`ifdef PIPE_STALL_CNT_EN
  output logic [CW-1:0]    count,
  output logic [31:0]      stall_cnt
`else
  output logic [CW-1:0]    count
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [PW-1:0]    head_q;
  logic [PW-1:0]    tail_q;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] rd_data;
  logic             push;
  logic             pop;

  // Modulo-DEPTH increment, valid for non-power-of-two depths.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  assign in_ready  = (count_q != FULL);
  assign out_valid = (count_q != '0);
  assign count     = count_q;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign out_data  = out_valid ? rd_data : WIDTH'(PIPE_NOP);

  pipe_buf_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .PW    (PW)
  ) u_mem (
    .clk   (clk),
    .we    (push & ~flush & ~rst),
    .waddr (tail_q),
    .wdata (in_data),
    .raddr (head_q),
    .rdata (rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) tail_q <= ptr_inc(tail_q);
      if (pop)  head_q <= ptr_inc(head_q);
      unique case (1'b1)
        push && !pop: count_q <= count_q + CW'(1);
        pop && !push: count_q <= count_q - CW'(1);
        default:      count_q <= count_q;
      endcase
    end
  end

`ifdef PIPE_STALL_CNT_EN
  logic [31:0] stall_q;

  // Flush deliberately leaves the counter alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else if (in_valid && !in_ready && stall_q != 32'hFFFF_FFFF) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule
